data_parity_merge: RTL and testbench

DATA_PARITY_MERGE -- requirements
Module: data_parity_merge

---
 rtl/data_parity_merge_pkg.sv | 25 ++
 rtl/parity_merge_arb.sv | 56 +++++
 rtl/data_parity_merge.sv | 97 +++++++++
 tb/tb_data_parity_merge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_parity_merge_pkg.sv
// Shared definitions for the parity merge/split blocks: arbiter state encoding,
// tuser bit layout and the byte parity function.
package data_parity_merge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ODD_PKT  = 2'd1,
      ST_EVEN_PKT = 2'd2
   } arb_state_t;

   localparam int   TUSER_W   = 2;
   localparam int   TUSER_SRC = 0;
   localparam int   TUSER_ERR = 1;

   localparam logic SRC_ODD   = 1'b1;
   localparam logic SRC_EVEN  = 1'b0;

   // Callers zero-extend into this width; zero padding leaves the XOR unchanged.
   localparam int   PARITY_MAX_W = 64;

   function automatic logic parity_of(input logic [PARITY_MAX_W-1:0] x);
      return ^x;
   endfunction

endpackage

// File: rtl/parity_merge_arb.sv
// Packet-level arbiter: grants one source until its tlast is accepted, ties in
// IDLE are broken round robin against the source granted last.
module parity_merge_arb
   import data_parity_merge_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       valid_odd,
   input  logic       valid_even,
   input  logic       done_odd,
   input  logic       done_even,
   output arb_state_t state
);

   arb_state_t state_nxt;
   logic       last_grant;
   logic       last_grant_nxt;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering; reset is synchronous here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= SRC_EVEN;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      unique case (state)
         ST_IDLE: begin
            if (valid_odd && (!valid_even || last_grant == SRC_EVEN)) begin
               state_nxt      = ST_ODD_PKT;
               last_grant_nxt = SRC_ODD;
            end else if (valid_even) begin
               state_nxt      = ST_EVEN_PKT;
               last_grant_nxt = SRC_EVEN;
            end
         end
         ST_ODD_PKT: begin
            if (done_odd) state_nxt = ST_IDLE;
         end
         ST_EVEN_PKT: begin
            if (done_even) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/data_parity_merge.sv
// Merges an odd-parity and an even-parity AXI-Stream into one registered output,
// tagging each byte with its source and a parity-error flag.
module data_parity_merge
   import data_parity_merge_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 a_clk,
   input  logic                 axis_aresetn,
   input  logic                 axis_s_tvalid_odd,
   input  logic [DATA_W-1:0]    axis_s_tdata_odd,
   input  logic                 axis_s_tlast_odd,
   output logic                 axis_s_tready_odd,
   input  logic                 axis_s_tvalid_even,
   input  logic [DATA_W-1:0]    axis_s_tdata_even,
   input  logic                 axis_s_tlast_even,
   output logic                 axis_s_tready_even,
   output logic                 axis_m_tvalid,
   output logic [DATA_W-1:0]    axis_m_tdata,
   output logic                 axis_m_tlast,
   output logic [TUSER_W-1:0]   axis_m_tuser,
   input  logic                 axis_m_tready,
   output logic [ERR_CNT_W-1:0] parity_err_count
);

   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   arb_state_t         state;
   logic               load_ok;
   logic               xfer_odd;
   logic               xfer_even;
   logic               xfer;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_last;
   logic               sel_src;
   logic               sel_err;
   logic [TUSER_W-1:0] sel_user;

   parity_merge_arb u_arb (
      .clk        (a_clk),
      .rst        (axis_aresetn),
      .valid_odd  (axis_s_tvalid_odd),
      .valid_even (axis_s_tvalid_even),
      .done_odd   (xfer_odd && axis_s_tlast_odd),
      .done_even  (xfer_even && axis_s_tlast_even),
      .state      (state)
   );

   // The reset name is historical: the reset is active-high.
   assign load_ok            = !axis_m_tvalid || axis_m_tready;
   assign axis_s_tready_odd  = !axis_aresetn && (state == ST_ODD_PKT)  && load_ok;
   assign axis_s_tready_even = !axis_aresetn && (state == ST_EVEN_PKT) && load_ok;

   assign xfer_odd  = axis_s_tvalid_odd  && axis_s_tready_odd;
   assign xfer_even = axis_s_tvalid_even && axis_s_tready_even;
   assign xfer      = xfer_odd || xfer_even;

   // Readies are mutually exclusive, so the odd handshake alone steers the mux.
   assign sel_src  = xfer_odd ? SRC_ODD : SRC_EVEN;
   assign sel_data = xfer_odd ? axis_s_tdata_odd : axis_s_tdata_even;
   assign sel_last = xfer_odd ? axis_s_tlast_odd : axis_s_tlast_even;

   // Odd bytes must carry parity 1, even bytes parity 0.
   assign sel_err  = parity_of(PARITY_MAX_W'(sel_data)) != sel_src;

   always_comb begin
      sel_user            = '0;
      sel_user[TUSER_SRC] = sel_src;
      sel_user[TUSER_ERR] = sel_err;
   end

   always_ff @(posedge a_clk) begin
      if (axis_aresetn) begin
         axis_m_tvalid <= 1'b0;
         axis_m_tdata  <= '0;
         axis_m_tlast  <= 1'b0;
         axis_m_tuser  <= '0;
      end else if (load_ok) begin
         axis_m_tvalid <= xfer;
         if (xfer) begin
            axis_m_tdata <= sel_data;
            axis_m_tlast <= sel_last;
            axis_m_tuser <= sel_user;
         end
      end
   end

   always_ff @(posedge a_clk) begin
      if (axis_aresetn) begin
         parity_err_count <= '0;
      end else if (xfer && sel_err && parity_err_count != ERR_MAX) begin
         parity_err_count <= parity_err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_data_parity_merge.sv
// Self-checking bench for data_parity_merge: directed scenarios plus random packets
// compared against a packet-level reference model of arbitration and parity.
module tb_data_parity_merge;

   localparam int DATA_W    = 8;
   localparam int ERR_CNT_W = 8;
   localparam int BUDGET    = 4000;
   localparam int ERR_SAT   = (1 << ERR_CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 s_valid_odd = 1'b0;
   logic [DATA_W-1:0]    s_data_odd = '0;
   logic                 s_last_odd = 1'b0;
   logic                 s_ready_odd;
   logic                 s_valid_even = 1'b0;
   logic [DATA_W-1:0]    s_data_even = '0;
   logic                 s_last_even = 1'b0;
   logic                 s_ready_even;
   logic                 m_valid;
   logic [DATA_W-1:0]    m_data;
   logic                 m_last;
   logic [1:0]           m_user;
   logic                 m_ready = 1'b1;
   logic [ERR_CNT_W-1:0] err_count;

   always #5 clk = ~clk;

   data_parity_merge #(.DATA_W(DATA_W), .ERR_CNT_W(ERR_CNT_W)) dut (
      .a_clk              (clk),
      .axis_aresetn       (rst),
      .axis_s_tvalid_odd  (s_valid_odd),
      .axis_s_tdata_odd   (s_data_odd),
      .axis_s_tlast_odd   (s_last_odd),
      .axis_s_tready_odd  (s_ready_odd),
      .axis_s_tvalid_even (s_valid_even),
      .axis_s_tdata_even  (s_data_even),
      .axis_s_tlast_even  (s_last_even),
      .axis_s_tready_even (s_ready_even),
      .axis_m_tvalid      (m_valid),
      .axis_m_tdata       (m_data),
      .axis_m_tlast       (m_last),
      .axis_m_tuser       (m_user),
      .axis_m_tready      (m_ready),
      .parity_err_count   (err_count)
   );

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
      logic [1:0]        user;
   } obeat_t;

   beat_t  odd_q[$];
   beat_t  even_q[$];
   obeat_t exp_q[$];
   obeat_t obs_q[$];

   int   checks = 0;
   int   errors = 0;
   logic model_last_odd = 1'b0;
   int   model_errs = 0;
   int   exp_beats = 0;
   int   exp_pkts = 0;
   int   last_acc_cycle = -1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Odd bytes are required to have parity 1, even bytes parity 0.
   function automatic logic [1:0] exp_user(input logic is_odd, input logic [DATA_W-1:0] d);
      logic want;
      want = is_odd ? 1'b1 : 1'b0;
      return {((^d) != want), is_odd};
   endfunction

   task automatic push_byte(input logic is_odd, input logic [DATA_W-1:0] d, input logic last);
      beat_t b;
      b.data = d;
      b.last = last;
      if (is_odd) odd_q.push_back(b);
      else        even_q.push_back(b);
   endtask

   // kind 0: correct parity, 1: wrong parity, 2: unconstrained random byte
   task automatic add_pkt(input logic is_odd, input int len, input int kind);
      logic [DATA_W-1:0] d;
      logic              target;
      for (int i = 0; i < len; i++) begin
         d = DATA_W'($urandom);
         target = (kind == 0) ? is_odd : ~is_odd;
         if (kind != 2 && (^d) != target) d[0] = ~d[0];
         push_byte(is_odd, d, i == len - 1);
      end
   endtask

   // Packet order: whenever both sources have a packet waiting, alternate with
   // the one granted last; otherwise take whichever has one.
   task automatic build_expected();
      beat_t  oq[$];
      beat_t  eq[$];
      beat_t  b;
      obeat_t o;
      logic   pick;
      oq = odd_q;
      eq = even_q;
      exp_beats = 0;
      exp_pkts  = 0;
      while (oq.size() > 0 || eq.size() > 0) begin
         pick = (oq.size() > 0) && (eq.size() == 0 || !model_last_odd);
         model_last_odd = pick;
         exp_pkts++;
         forever begin
            if (pick ? oq.size() == 0 : eq.size() == 0) break;
            b = pick ? oq.pop_front() : eq.pop_front();
            o.data = b.data;
            o.last = b.last;
            o.user = exp_user(pick, b.data);
            if (o.user[1]) model_errs++;
            exp_q.push_back(o);
            exp_beats++;
            if (b.last) break;
         end
      end
   endtask

   // rmode 0: m_ready always 1, 1: random m_ready, 2: m_ready low for 5 cycles from stall_at
   task automatic run(input int rmode, input int stall_at, input int stop_after);
      int     cycle;
      int     accepts;
      logic   have_prev;
      logic   have_hold;
      logic   done;
      obeat_t prev;
      obeat_t hold;
      obeat_t cur;
      cycle = 0; accepts = 0; have_prev = 0; have_hold = 0; done = 0;
      prev = '0; hold = '0;
      last_acc_cycle = -1;
      while (!done && cycle < BUDGET) begin
         @(negedge clk);
         if (stop_after >= 0 && accepts >= stop_after) begin
            s_valid_odd  = 1'b0;
            s_valid_even = 1'b0;
            done = 1;
            break;
         end
         s_valid_odd  = odd_q.size() > 0;
         s_data_odd   = (odd_q.size() > 0) ? odd_q[0].data : '0;
         s_last_odd   = (odd_q.size() > 0) ? odd_q[0].last : 1'b0;
         s_valid_even = even_q.size() > 0;
         s_data_even  = (even_q.size() > 0) ? even_q[0].data : '0;
         s_last_even  = (even_q.size() > 0) ? even_q[0].last : 1'b0;
         case (rmode)
            1:       m_ready = $urandom_range(0, 3) != 0;
            2:       m_ready = !(cycle >= stall_at && cycle < stall_at + 5);
            default: m_ready = 1'b1;
         endcase
         #1;
         cur.data = m_data;
         cur.last = m_last;
         cur.user = m_user;
         if (have_prev) begin
            check("latency_valid", 64'(m_valid), 64'(1));
            check("latency_beat", 64'(cur), 64'(prev));
         end
         if (have_hold) check("hold_stable", 64'(cur), 64'(hold));
         check("ready_exclusive", 64'(s_ready_odd & s_ready_even), 64'(0));
         if (m_valid && !m_ready) check("stall_ready_low", 64'({s_ready_odd, s_ready_even}), 64'(0));
         have_prev = 0;
         if (s_valid_odd && s_ready_odd) begin
            prev.data = odd_q[0].data;
            prev.last = odd_q[0].last;
            prev.user = exp_user(1'b1, odd_q[0].data);
            void'(odd_q.pop_front());
            have_prev = 1;
         end else if (s_valid_even && s_ready_even) begin
            prev.data = even_q[0].data;
            prev.last = even_q[0].last;
            prev.user = exp_user(1'b0, even_q[0].data);
            void'(even_q.pop_front());
            have_prev = 1;
         end
         if (have_prev) begin
            accepts++;
            last_acc_cycle = cycle;
         end
         if (m_valid && m_ready) obs_q.push_back(cur);
         have_hold = m_valid && !m_ready;
         hold = cur;
         cycle++;
         if (odd_q.size() == 0 && even_q.size() == 0 && !have_prev && !have_hold) done = 1;
      end
      check("run_done", 64'(done), 64'(1));
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_beats"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check({tag, "_beat"}, 64'(obs_q[i]), 64'(exp_q[i]));
      check({tag, "_err_count"}, 64'(err_count),
            64'((model_errs > ERR_SAT) ? ERR_SAT : model_errs));
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("reset_ready_low", 64'({s_ready_odd, s_ready_even}), 64'(0));
      rst = 1'b0;
      model_last_odd = 1'b0;
      model_errs = 0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_m_valid", 64'(m_valid), 64'(0));
      check("rst_m_data", 64'(m_data), 64'(0));
      check("rst_m_last", 64'(m_last), 64'(0));
      check("rst_m_user", 64'(m_user), 64'(0));
      check("rst_err_count", 64'(err_count), 64'(0));

      // Single odd packet 0x01, 0x07
      push_byte(1'b1, 8'h01, 1'b0);
      push_byte(1'b1, 8'h07, 1'b1);
      build_expected();
      run(0, 0, -1);
      check("single_throughput", 64'(last_acc_cycle), 64'(exp_beats + exp_pkts - 1));
      compare_stream("single_odd");

      // Both sources valid from reset: odd wins the first tie, no interleave
      do_reset();
      push_byte(1'b1, 8'h01, 1'b0);
      push_byte(1'b1, 8'h02, 1'b0);
      push_byte(1'b1, 8'h04, 1'b1);
      push_byte(1'b0, 8'h03, 1'b0);
      push_byte(1'b0, 8'h05, 1'b0);
      push_byte(1'b0, 8'h00, 1'b1);
      build_expected();
      check("tie_first_src", 64'(exp_q[0].user[0]), 64'(1));
      run(0, 0, -1);
      check("tie_throughput", 64'(last_acc_cycle), 64'(7));
      compare_stream("tie_rr");

      // Even byte with odd parity flags an error
      push_byte(1'b0, 8'h01, 1'b1);
      build_expected();
      run(0, 0, -1);
      check("even_err_user", 64'(m_user), 64'(2'b10));
      compare_stream("even_err");

      // Downstream stall mid-packet
      add_pkt(1'b1, 6, 0);
      build_expected();
      run(2, 3, -1);
      compare_stream("stall");

      // Random packets with random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int p = 0; p < 5; p++) add_pkt(1'($urandom), $urandom_range(1, 4), 2);
         build_expected();
         run(1, 0, -1);
         compare_stream("random");
      end

      // Counter saturation with 300 parity errors
      do_reset();
      add_pkt(1'b0, 300, 1);
      build_expected();
      run(0, 0, -1);
      check("sat_count", 64'(err_count), 64'(ERR_SAT));
      compare_stream("saturate");

      // Reset in the middle of an odd packet with a held output byte
      do_reset();
      add_pkt(1'b1, 5, 1);
      run(2, 3, 2);
      m_ready = 1'b0;
      #1;
      check("pre_reset_count", 64'(err_count), 64'(2));
      check("pre_reset_held", 64'(m_valid), 64'(1));
      obs_q.delete();
      odd_q.delete();
      do_reset();
      m_ready = 1'b1;
      check("mid_rst_m_valid", 64'(m_valid), 64'(0));
      check("mid_rst_count", 64'(err_count), 64'(0));
      @(negedge clk);
      #1;
      check("mid_rst_idle_ready", 64'({s_ready_odd, s_ready_even}), 64'(0));
      add_pkt(1'b0, 3, 2);
      build_expected();
      run(0, 0, -1);
      check("post_rst_throughput", 64'(last_acc_cycle), 64'(exp_beats + exp_pkts - 1));
      compare_stream("post_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
